// File: rtl/oled_init_sequencer.sv
// Power-up sequencer for the SPI-attached OLED panel: walks a fixed step table of
// supply/reset pin changes, SPI command bytes and handshaked delays.
module oled_init_sequencer #(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned PTR_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] spi_data,
  output logic       spi_start,
  input  logic       spi_done,
  output logic       dly_en,
  input  logic       delay_done,
  output logic       vdd_n,
  output logic       vbat_n,
  output logic       res_n,
  output logic       dc,
  output logic       busy,
  output logic       init_done,
  output logic       err
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] OpSend  = 2'd0;
  localparam logic [1:0] OpDelay = 2'd1;
  localparam logic [1:0] OpPins  = 2'd2;
  localparam logic [1:0] OpEnd   = 2'd3;

  typedef enum logic [2:0] {
    StIdle, StFetch, StSend, StWaitSpi, StDelay, StGap, StDone, StError
  } state_e;

  // Step layout is {op, arg}; for PINS, arg[2:0] = {vbat_n, res_n, vdd_n}.
  function automatic logic [9:0] step_rom(input logic [PTR_W-1:0] p);
    logic [9:0] s;
    case (int'(p))
      0:       s = {OpPins,  8'h06};
      1:       s = {OpDelay, 8'h00};
      2:       s = {OpSend,  8'hAE};
      3:       s = {OpPins,  8'h04};
      4:       s = {OpDelay, 8'h00};
      5:       s = {OpPins,  8'h06};
      6:       s = {OpSend,  8'h8D};
      7:       s = {OpSend,  8'h14};
      8:       s = {OpPins,  8'h02};
      9:       s = {OpDelay, 8'h00};
      10:      s = {OpSend,  8'hAF};
      default: s = {OpEnd,   8'h00};
    endcase
    return s;
  endfunction

  state_e           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [7:0]       spi_data_q, spi_data_d;
  logic             dly_en_q, dly_en_d;
  logic [2:0]       pins_q, pins_d;
  logic             init_done_q, init_done_d;
  logic             err_q, err_d;
  logic [9:0]       step;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    spi_data_d  = spi_data_q;
    dly_en_d    = dly_en_q;
    pins_d      = pins_q;
    init_done_d = init_done_q;
    err_d       = err_q;
    step        = step_rom(ptr_q);

    case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        case (step[9:8])
          OpPins: begin
            pins_d = step[2:0];
            ptr_d  = ptr_q + PTR_W'(1);
          end
          OpSend: begin
            spi_data_d = step[7:0];
            state_d    = StSend;
          end
          OpDelay: begin
            dly_en_d = 1'b1;
            state_d  = StDelay;
          end
          default: begin
            init_done_d = 1'b1;
            state_d     = StDone;
          end
        endcase
      end
      StSend: begin
        cnt_d   = '0;
        state_d = StWaitSpi;
      end
      StWaitSpi: begin
        // A completion on the final allowed cycle still counts as success.
        if (spi_done) begin
          ptr_d   = ptr_q + PTR_W'(1);
          state_d = StFetch;
        end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = StError;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDelay: begin
        if (delay_done) begin
          dly_en_d = 1'b0;
          ptr_d    = ptr_q + PTR_W'(1);
          state_d  = StGap;
        end
      end
      StGap: begin
        state_d = StFetch;
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      cnt_q       <= '0;
      spi_data_q  <= 8'h00;
      dly_en_q    <= 1'b0;
      pins_q      <= 3'b111;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      spi_data_q  <= spi_data_d;
      dly_en_q    <= dly_en_d;
      pins_q      <= pins_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
    end
  end

  assign spi_data  = spi_data_q;
  assign spi_start = (state_q == StSend);
  assign dly_en    = dly_en_q;
  assign vbat_n    = pins_q[2];
  assign res_n     = pins_q[1];
  assign vdd_n     = pins_q[0];
  assign dc        = 1'b0;
  assign busy      = !(state_q inside {StIdle, StDone, StError});
  assign init_done = init_done_q;
  assign err       = err_q;

endmodule
